// File: rtl/memory_pkg.sv
// Shared types, sizes and helpers for the 4x4 memory-game datapath.
package memory_pkg;

    localparam int N_CARDS = 16;
    localparam int N_PAIRS = 8;

    typedef logic [2:0]           symbol_t;
    typedef logic [3:0]           card_idx_t;
    typedef logic [N_CARDS-1:0]   card_mask_t;
    typedef logic [N_CARDS*3-1:0] board_t;

    // Card 2p and 2p+1 both carry symbol p, so neighbouring cards pair up.
    localparam board_t BOARD_DEFAULT = {6'd63, 6'd54, 6'd45, 6'd36, 6'd27, 6'd18, 6'd9, 6'd0};

    function automatic symbol_t symbol_at(input board_t board, input card_idx_t idx);
        return board[3*idx +: 3];
    endfunction

    function automatic card_idx_t lowest_set(input card_mask_t mask);
        card_idx_t idx;
        idx = '0;
        for (int k = N_CARDS - 1; k >= 0; k--)
            if (mask[k]) idx = card_idx_t'(k);
        return idx;
    endfunction

    function automatic logic [3:0] score_inc(input logic [3:0] score);
        return (score >= 4'(N_PAIRS)) ? score : score + 4'd1;
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter that steps once per enabled tick and stops at zero.
module tick_down_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_value,
    input  logic             load,
    input  logic             tick,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= RESET_VALUE;
        else if (load)
            count <= load_value;
        else if (tick && enable && !zero)
            count <= count - WIDTH'(1);
    end

endmodule

// File: rtl/memory_datapath.sv
// Board, cursor, selection, scoring and timing datapath for the memory game;
// the controller sequences it through one-cycle command pulses.
module memory_datapath
    import memory_pkg::*;
#(
    parameter int TURN_S  = 15,
    parameter int PAUSE_S = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz_i,
    input  logic        load_i,
    input  logic [47:0] board_i,
    input  logic        btn_up_i,
    input  logic        btn_down_i,
    input  logic        btn_left_i,
    input  logic        btn_right_i,
    input  logic        select_first_i,
    input  logic        select_second_i,
    input  logic        auto_select_first_i,
    input  logic        auto_select_second_i,
    input  logic        match_found_i,
    input  logic        start_pause_i,
    input  logic        end_turn_i,
    input  logic        extra_turn_i,
    input  logic        restart_timer_i,
    output logic        time_up_o,
    output logic        cards_match_o,
    output logic        pause_done_o,
    output logic        auto_pick1_valid_o,
    output logic        auto_pick2_valid_o,
    output logic        match_happened_o,
    output logic        game_over_o,
    output logic [3:0]  cursor_o,
    output logic [15:0] face_up_o,
    output logic [15:0] matched_o,
    output logic        player_o,
    output logic [3:0]  score0_o,
    output logic [3:0]  score1_o,
    output logic [3:0]  timer_o
);

    localparam logic [3:0] TURN_LD  = 4'(TURN_S);
    localparam logic [3:0] PAUSE_LD = 4'(PAUSE_S);

    board_t     board;
    card_idx_t  cursor, cursor_nxt, first_idx, second_idx;
    card_idx_t  auto_idx1, auto_idx2, cand;
    card_mask_t face_up, face_up_nxt, matched, matched_nxt, avail1, avail2;
    logic [3:0] score0, score1, pause_count;
    logic       player, pause_active, match_happened, game_over, pause_zero;

    tick_down_counter #(.WIDTH(4), .RESET_VALUE(TURN_LD)) u_turn_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_value (TURN_LD),
        .load       (restart_timer_i | extra_turn_i | end_turn_i | load_i),
        .tick       (tick_1hz_i),
        .enable     (!pause_active && !game_over),
        .count      (timer_o),
        .zero       (time_up_o)
    );

    tick_down_counter #(.WIDTH(4), .RESET_VALUE(4'd0)) u_pause_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_value (PAUSE_LD),
        .load       (start_pause_i && !load_i),
        .tick       (tick_1hz_i),
        .enable     (pause_active),
        .count      (pause_count),
        .zero       (pause_zero)
    );

    assign avail1             = ~matched & ~face_up;
    assign avail2             = avail1 & ~(card_mask_t'(1) << first_idx);
    assign auto_idx1          = lowest_set(avail1);
    assign auto_idx2          = lowest_set(avail2);
    assign auto_pick1_valid_o = |avail1;
    assign auto_pick2_valid_o = |avail2;
    assign cand               = time_up_o ? auto_idx2 : cursor;
    assign cards_match_o      = (symbol_at(board, cand) == symbol_at(board, first_idx))
                                && (cand != first_idx) && !matched[cand];
    assign pause_done_o       = pause_active && pause_zero;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cursor_nxt = cursor;
        if (!pause_active && !game_over) begin
            if (btn_up_i)         cursor_nxt = {cursor[3:2] - 2'd1, cursor[1:0]};
            else if (btn_down_i)  cursor_nxt = {cursor[3:2] + 2'd1, cursor[1:0]};
            else if (btn_left_i)  cursor_nxt = {cursor[3:2], cursor[1:0] - 2'd1};
            else if (btn_right_i) cursor_nxt = {cursor[3:2], cursor[1:0] + 2'd1};
        end
    end

    // Reveals first, then clears, so a match in the same cycle as a reveal wins.
    always_comb begin
        face_up_nxt = face_up;
        matched_nxt = matched;
        if (select_first_i)            face_up_nxt[cursor]    = 1'b1;
        else if (auto_select_first_i)  face_up_nxt[auto_idx1] = 1'b1;
        if (select_second_i)           face_up_nxt[cursor]    = 1'b1;
        else if (auto_select_second_i) face_up_nxt[auto_idx2] = 1'b1;
        if (match_found_i) begin
            matched_nxt[first_idx] = 1'b1;
            matched_nxt[cand]      = 1'b1;
            face_up_nxt[first_idx] = 1'b0;
            face_up_nxt[cand]      = 1'b0;
        end
        if (end_turn_i) begin
            face_up_nxt[first_idx]  = 1'b0;
            face_up_nxt[second_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the board is an ordinary register bank, so it takes a reset value like any other flop.
            board          <= BOARD_DEFAULT;
            cursor         <= '0;
            face_up        <= '0;
            matched        <= '0;
            first_idx      <= '0;
            second_idx     <= '0;
            score0         <= '0;
            score1         <= '0;
            player         <= 1'b0;
            pause_active   <= 1'b0;
            match_happened <= 1'b0;
            game_over      <= 1'b0;
        end else if (load_i) begin
            board          <= board_i;
            cursor         <= '0;
            face_up        <= '0;
            matched        <= '0;
            first_idx      <= '0;
            second_idx     <= '0;
            score0         <= '0;
            score1         <= '0;
            player         <= 1'b0;
            pause_active   <= 1'b0;
            match_happened <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            cursor         <= cursor_nxt;
            face_up        <= face_up_nxt;
            matched        <= matched_nxt;
            match_happened <= match_found_i;
            game_over      <= game_over | (matched == '1);
            if (select_first_i)            first_idx  <= cursor;
            else if (auto_select_first_i)  first_idx  <= auto_idx1;
            if (select_second_i)           second_idx <= cursor;
            else if (auto_select_second_i) second_idx <= auto_idx2;
            if (match_found_i) begin
                if (player) score1 <= score_inc(score1);
                else        score0 <= score_inc(score0);
            end
            if (start_pause_i) pause_active <= 1'b1;
            if (end_turn_i) begin
                pause_active <= 1'b0;
                player       <= ~player;
            end
        end
    end

    assign cursor_o         = cursor;
    assign face_up_o        = face_up;
    assign matched_o        = matched;
    assign player_o         = player;
    assign score0_o         = score0;
    assign score1_o         = score1;
    assign match_happened_o = match_happened;
    assign game_over_o      = game_over;

endmodule

// File: tb/tb_memory_datapath.sv
// Directed-vector bench for memory_datapath: timer, match, mismatch/pause,
// cursor wrap, auto picks, game over, load and reset behaviour.
module tb_memory_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick, load, btn_up, btn_down, btn_left, btn_right;
    logic        sel_first, sel_second, auto_first, auto_second;
    logic        match_found, start_pause, end_turn, extra_turn, restart_timer;
    logic [47:0] board_in;
    logic        time_up, cards_match, pause_done, pick1_valid, pick2_valid;
    logic        match_happened, game_over, player;
    logic [3:0]  cursor, score0, score1, timer;
    logic [15:0] face_up, matched;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_datapath #(.TURN_S(15), .PAUSE_S(2)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tick_1hz_i           (tick),
        .load_i               (load),
        .board_i              (board_in),
        .btn_up_i             (btn_up),
        .btn_down_i           (btn_down),
        .btn_left_i           (btn_left),
        .btn_right_i          (btn_right),
        .select_first_i       (sel_first),
        .select_second_i      (sel_second),
        .auto_select_first_i  (auto_first),
        .auto_select_second_i (auto_second),
        .match_found_i        (match_found),
        .start_pause_i        (start_pause),
        .end_turn_i           (end_turn),
        .extra_turn_i         (extra_turn),
        .restart_timer_i      (restart_timer),
        .time_up_o            (time_up),
        .cards_match_o        (cards_match),
        .pause_done_o         (pause_done),
        .auto_pick1_valid_o   (pick1_valid),
        .auto_pick2_valid_o   (pick2_valid),
        .match_happened_o     (match_happened),
        .game_over_o          (game_over),
        .cursor_o             (cursor),
        .face_up_o            (face_up),
        .matched_o            (matched),
        .player_o             (player),
        .score0_o             (score0),
        .score1_o             (score1),
        .timer_o              (timer)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        tick = 0; load = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        sel_first = 0; sel_second = 0; auto_first = 0; auto_second = 0;
        match_found = 0; start_pause = 0; end_turn = 0; extra_turn = 0; restart_timer = 0;
    endtask

    // Inputs set before the call are captured at the next edge, then dropped.
    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        board_in = '0;
        rst_n    = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        check("rst_timer", timer, 15);
        check("rst_cursor", cursor, 0);
        check("rst_face_up", face_up, 0);
        check("rst_matched", matched, 0);
        check("rst_player", player, 0);
        check("rst_scores", {score0, score1}, 0);
        check("rst_time_up", time_up, 0);
        check("rst_flags", {game_over, match_happened, pause_done}, 0);
        check("rst_pick1_valid", pick1_valid, 1);

        // Turn timer counts 15..0 and holds at zero
        for (int i = 1; i <= 15; i++) begin
            ticks(1);
            check("timer_countdown", timer, 48'(15 - i));
        end
        check("time_up_at_zero", time_up, 1);
        ticks(2);
        check("timer_holds_zero", timer, 0);
        tick = 1; restart_timer = 1; step();
        check("reload_beats_tick", timer, 15);
        check("time_up_cleared", time_up, 0);

        // Matching pair 0/1 on the default board
        sel_first = 1; step();
        check("first_face_up", face_up, 16'h0001);
        btn_right = 1; step();
        check("cursor_right", cursor, 1);
        check("match_pair01", cards_match, 1);
        sel_second = 1; match_found = 1; step();
        check("matched_01", matched, 16'h0003);
        check("face_up_after_match", face_up, 0);
        check("score0_one", score0, 1);
        check("match_pulse_high", match_happened, 1);
        step();
        check("match_pulse_low", match_happened, 0);
        check("player_kept", player, 0);

        // Mismatch 2 (sym 1) vs 6 (sym 3), pause, end turn
        btn_right = 1; step();
        sel_first = 1; step();
        check("face_up_card2", face_up, 16'h0004);
        btn_down = 1; step();
        check("cursor_down", cursor, 6);
        check("no_match_2_6", cards_match, 0);
        sel_second = 1; step();
        check("face_up_2_6", face_up, 16'h0044);
        start_pause = 1; step();
        check("pause_not_done", pause_done, 0);
        ticks(1);
        check("pause_one_left", pause_done, 0);
        check("timer_frozen_in_pause", timer, 15);
        ticks(1);
        check("pause_done", pause_done, 1);
        btn_up = 1; step();
        check("cursor_frozen_in_pause", cursor, 6);
        end_turn = 1; step();
        check("end_turn_face_up", face_up, 0);
        check("end_turn_player", player, 1);
        check("end_turn_timer", timer, 15);
        check("end_turn_pause_done", pause_done, 0);

        // Cursor wrap in both axes
        btn_up = 1; step();
        btn_right = 1; step();
        check("cursor_at_3", cursor, 3);
        btn_right = 1; step();
        check("wrap_right", cursor, 0);
        btn_up = 1; step();
        check("wrap_up", cursor, 12);
        btn_down = 1; step();
        check("wrap_down", cursor, 0);

        // Time-up auto picks with cards 0/1 matched
        ticks(15);
        check("time_up_again", time_up, 1);
        auto_first = 1; step();
        check("auto_pick1_card2", face_up, 16'h0004);
        check("auto_match_2_3", cards_match, 1);
        auto_second = 1; match_found = 1; step();
        check("matched_0_3", matched, 16'h000F);
        check("score1_one", score1, 1);
        for (int p = 0; p < 5; p++) begin
            auto_first = 1; step();
            auto_second = 1; match_found = 1; step();
        end
        check("matched_0_13", matched, 16'h3FFF);
        check("score1_six", score1, 6);

        // Leave only first_idx (card 14) available
        btn_up = 1; step();
        btn_left = 1; step();
        check("cursor_15", cursor, 15);
        sel_second = 1; step();
        auto_first = 1; step();
        check("face_up_14_15", face_up, 16'hC000);
        btn_left = 1; step();
        sel_second = 1; step();
        end_turn = 1; step();
        check("face_up_15_only", face_up, 16'h8000);
        check("player_back_0", player, 0);
        check("pick1_valid_14", pick1_valid, 1);
        check("pick2_invalid", pick2_valid, 0);

        // Final pair and game over
        btn_right = 1; step();
        check("match_14_15", cards_match, 1);
        match_found = 1; step();
        check("matched_all", matched, 16'hFFFF);
        check("score0_two", score0, 2);
        check("game_over_not_yet", game_over, 0);
        step();
        check("game_over", game_over, 1);
        ticks(2);
        check("timer_frozen_game_over", timer, 15);
        btn_down = 1; step();
        check("cursor_frozen_game_over", cursor, 15);

        // Load a custom board: card0=1, card1=2, card2=1
        board_in = 48'h51; load = 1; btn_up = 1; match_found = 1; step();
        check("load_game_over", game_over, 0);
        check("load_matched", matched, 0);
        check("load_scores", {score0, score1}, 0);
        check("load_cursor", cursor, 0);
        check("load_timer", timer, 15);
        check("load_match_happened", match_happened, 0);
        btn_right = 1; step();
        check("custom_no_match", cards_match, 0);
        btn_right = 1; step();
        check("custom_match", cards_match, 1);

        // Reset in the middle of a pause
        sel_first = 1; step();
        start_pause = 1; step();
        ticks(2);
        check("pre_reset_pause_done", pause_done, 1);
        rst_n = 0;
        #1;
        check("reset_face_up", face_up, 0);
        check("reset_pause_done", pause_done, 0);
        check("reset_cursor", cursor, 0);
        @(negedge clk);
        rst_n = 1;
        btn_right = 1; step();
        check("reset_board_default", cards_match, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_datapath.md
MEMORY_DATAPATH -- requirements
Module: memory_datapath

Interface
REQ-001 SHALL have parameters: TURN_S default 15, turn time in seconds; PAUSE_S default 2, mismatch display time in seconds.
REQ-002 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: tick_1hz_i  in  1  one-cycle pulse per second; load_i  in  1  board load strobe; board_i  in  48  16 cards x 3-bit symbol, card k at bits [3k+2:3k].
REQ-004 SHALL have ports: btn_up_i, btn_down_i, btn_left_i, btn_right_i  in  1 each  debounced one-cycle cursor pulses.
REQ-005 SHALL have ports: select_first_i, select_second_i, auto_select_first_i, auto_select_second_i, match_found_i, start_pause_i, end_turn_i, extra_turn_i, restart_timer_i  in  1 each  controller command pulses.
REQ-006 SHALL have ports: time_up_o, cards_match_o, pause_done_o, auto_pick1_valid_o, auto_pick2_valid_o, match_happened_o, game_over_o  out  1 each  status to controller.
REQ-007 SHALL have ports: cursor_o  out  4  cursor index; face_up_o  out  16  revealed mask; matched_o  out  16  matched mask; player_o  out  1  current player; score0_o, score1_o  out  4  pairs per player; timer_o  out  4  seconds left.

Function
REQ-008 SHALL model a 4x4 board; index = row*4+col.
REQ-009 SHALL move cursor on btn pulses: up/down change row, left/right change column, each wrapping modulo 4 within its axis; with simultaneous pulses, priority up>down>left>right; moves ignored while pause_active or game_over_o.
REQ-010 SHALL define available(k) = !matched[k] && !face_up[k].
REQ-011 SHALL drive auto_pick1_valid_o = any card available; auto_idx1 = lowest available index.
REQ-012 SHALL drive auto_pick2_valid_o = any card available other than first_idx; auto_idx2 = lowest such index.
REQ-013 SHALL compute cand = time_up_o ? auto_idx2 : cursor_o; cards_match_o combinational = (sym[cand]==sym[first_idx]) && cand!=first_idx && !matched[cand].
REQ-014 On select_first_i SHALL register first_idx=cursor_o and set face_up[cursor]; on auto_select_first_i use auto_idx1.
REQ-015 On select_second_i SHALL register second_idx=cursor_o and set face_up[cursor]; on auto_select_second_i use auto_idx2; selecting first_idx again is accepted as mismatch.
REQ-016 On match_found_i SHALL set matched and clear face_up for first_idx and second candidate in the same cycle, increment score of player_o (saturate 8), and pulse match_happened_o exactly one cycle later.
REQ-017 game_over_o SHALL be registered, high when matched_o==16'hFFFF, held until reset or load_i.
REQ-018 Turn timer SHALL reload to TURN_S on restart_timer_i, extra_turn_i, end_turn_i or load_i; decrement on tick_1hz_i when >0, not pause_active, not game_over_o; time_up_o = (timer==0) combinational.
REQ-019 start_pause_i SHALL set pause_active and load pause counter PAUSE_S; counter decrements per tick; pause_done_o = pause_active && count==0, held until end_turn_i.
REQ-020 On end_turn_i SHALL clear face_up for first_idx and second_idx, clear pause_active, toggle player_o.
REQ-021 extra_turn_i SHALL not change player_o.
REQ-022 Simultaneous tick_1hz_i and reload SHALL result in reload value.
REQ-023 load_i SHALL latch board_i, clear masks, scores, pause, set player 0, cursor 0, timer TURN_S; load_i dominates all other commands.

Reset
REQ-024 On rst_n low SHALL: board = BOARD_DEFAULT, cursor 0, masks 0, scores 0, player 0, timer TURN_S, pause inactive, first/second idx 0, match_happened_o 0, game_over_o 0.
REQ-025 Reset mid-pause or mid-turn SHALL abandon the turn with no residual face_up or pause_done_o.

Structure
REQ-026 Package memory_pkg SHALL hold N_CARDS=16, N_PAIRS=8, symbol_t (3-bit), card_idx_t (4-bit), BOARD_DEFAULT (48-bit, each symbol 0-7 twice).
REQ-027 SHALL instantiate sub-module tick_down_counter (load value, load, tick, enable, count, zero) twice: turn timer and pause counter.

Verification
REQ-028 Reset then tick_1hz_i x15 -> timer_o 15..0, time_up_o high after 15th tick, stays 0 on further ticks.
REQ-029 BOARD_DEFAULT, select_first at 0, cursor to matching card, select_second + match_found -> matched bits set, score0_o=1, match_happened_o one-cycle pulse next cycle, player_o 0.
REQ-030 Mismatch: select two differing cards, start_pause, 2 ticks -> pause_done_o high; end_turn -> face_up_o 0, player_o=1, timer_o=15.
REQ-031 Matched cards 0-1 and time_up: auto_pick1 selects card 2; auto_pick2 with only first_idx available -> auto_pick2_valid_o 0.
REQ-032 Cursor at 3, btn_right -> 0; at 0, btn_up -> 12; buttons during pause -> no change.
REQ-033 Match all 8 pairs -> game_over_o high; ticks no longer decrement timer; load_i clears game_over_o.
